// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU). It sits beside the execute-stage ALU.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset; aborts any in-flight operation
//   start  - request strobe, sampled only while busy=0
//   op     - 4-bit operation code (4'b1000..4'b1111 are M ops)
//   A, B   - operands rs1/rs2, captured on the accepting edge
//   busy   - iterative operation in progress; new starts are ignored
//   done   - one-cycle pulse; result is valid in this cycle
//   result - last completed result, held until the next completion
//
// Optional feature: define MULDIV_FAST_MUL_EN to compute all multiplies with
// a single-cycle combinational multiplier. Divides stay iterative.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [4:0]        count_reg, count_next;
  logic [2:0]        op_reg, op_next;
  logic [XLEN-1:0]   mag_b_reg, mag_b_next;
  logic              neg_q_reg, neg_q_next;
  logic              neg_r_reg, neg_r_next;
  logic [2*XLEN-1:0] acc_reg, acc_next;
  logic              done_reg, done_next;
  logic [XLEN-1:0]   result_reg, result_next;

  // Request decode on the live inputs (only meaningful while idle).
  logic            signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0] abs_a, abs_b;

  assign signed_a = op inside {4'b1001, 4'b1010, 4'b1100, 4'b1110};
  assign signed_b = op inside {4'b1001, 4'b1100, 4'b1110};
  assign sign_a   = signed_a & A[XLEN-1];
  assign sign_b   = signed_b & B[XLEN-1];
  assign abs_a    = sign_a ? -A : A;
  assign abs_b    = sign_b ? -B : B;

  // Shift-add multiply step: acc = {partial product, remaining multiplier}.
  // The multiplier LSB decides the add, then everything shifts right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                    (acc_reg[0] ? {1'b0, mag_b_reg} : {(XLEN+1){1'b0}});
  assign mul_step = {mul_sum, acc_reg[XLEN-1:1]};

  // Restoring divide step: acc = {remainder, dividend/quotient}. The next
  // dividend bit shifts into the remainder; a non-negative trial difference
  // keeps the subtraction and shifts in a quotient 1.
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_step;
  assign div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mag_b_reg};
  assign div_step  = div_diff[XLEN]
                   ? {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0}
                   : {div_diff[XLEN-1:0],  acc_reg[XLEN-2:0], 1'b1};

  // Sign fix-up applied on the final iteration.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_val;
  assign prod_fix  = neg_q_reg ? -mul_step : mul_step;
  assign quo_fix   = neg_q_reg ? -div_step[XLEN-1:0] : div_step[XLEN-1:0];
  assign rem_fix   = neg_r_reg ? -div_step[2*XLEN-1:XLEN] : div_step[2*XLEN-1:XLEN];
  assign final_val = op_reg[2]
                   ? (op_reg[1] ? rem_fix : quo_fix)
                   : ((op_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

`ifdef MULDIV_FAST_MUL_EN
  // Operands extended per op (sign bit only where the op is signed); the low
  // 2*XLEN bits of the modular product equal the 33x33 signed product.
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]   fast_val;
  assign fast_a    = {{XLEN{sign_a}}, A};
  assign fast_b    = {{XLEN{sign_b}}, B};
  assign fast_prod = fast_a * fast_b;
  assign fast_val  = (op[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    op_next     = op_reg;
    mag_b_next  = mag_b_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    acc_next    = acc_reg;
    done_next   = 1'b0;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (!op[3]) begin
            result_next = '0;
            done_next   = 1'b1;
          end else if (op[2] && (B == '0)) begin
            result_next = op[1] ? A : '1;
            done_next   = 1'b1;
          end else if (op[2] && !op[0] && (A == MIN_INT) && (B == '1)) begin
            result_next = op[1] ? '0 : MIN_INT;
            done_next   = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!op[2]) begin
            result_next = fast_val;
            done_next   = 1'b1;
`endif
          end else begin
            state_next = CALC;
            count_next = 5'd31;
            op_next    = op[2:0];
            mag_b_next = abs_b;
            neg_q_next = sign_a ^ sign_b;
            neg_r_next = sign_a;
            acc_next   = {{XLEN{1'b0}}, abs_a};
          end
        end
      end
      CALC: begin
        acc_next   = op_reg[2] ? div_step : mul_step;
        count_next = count_reg - 5'd1;
        if (count_reg == 5'd0) begin
          result_next = final_val;
          done_next   = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      op_reg     <= '0;
      mag_b_reg  <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      acc_reg    <= '0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      op_reg     <= op_next;
      mag_b_reg  <= mag_b_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      acc_reg    <= acc_next;
      done_reg   <= done_next;
      result_reg <= result_next;
    end
  end

  assign busy   = (state_reg == CALC);
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors with literal results,
// reset abort, busy-start rejection, back-to-back issue and randomized traffic.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] MIN_INT = 32'h80000000;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result of one request, from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    r = '0;
    case (o)
      4'b1000: begin p = sa * sb; r = p[31:0];  end
      4'b1001: begin p = sa * sb; r = p[63:32]; end
      4'b1010: begin p = sa * ub; r = p[63:32]; end
      4'b1011: begin p = ua * ub; r = p[63:32]; end
      4'b1100: if (b == 0) r = '1;
               else if (a == MIN_INT && b == '1) r = MIN_INT;
               else r = $signed(a) / $signed(b);
      4'b1101: r = (b == 0) ? '1 : a / b;
      4'b1110: if (b == 0) r = a;
               else if (a == MIN_INT && b == '1) r = '0;
               else r = $signed(a) % $signed(b);
      4'b1111: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Cycles from the start cycle to the done cycle.
  function automatic int ref_lat(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    if (!o[3]) return 1;
    if (o[2] && b == 0) return 1;
    if (o[2] && !o[0] && a == MIN_INT && b == '1) return 1;
    if (!o[2]) return MUL_LAT;
    return 33;
  endfunction

  // Per-cycle compare process with a transaction-level model: at most one
  // outstanding request, known value and known completion cycle.
  int          cyc = 0;
  bit          m_pending = 0;
  int          m_due = 0;
  int          m_lat = 0;
  logic [31:0] m_val = '0;
  logic [31:0] m_result = '0;

  initial begin
    logic exp_done, exp_busy;
    logic [31:0] exp_res;
    forever begin
      @(negedge clk);
      exp_done = m_pending && (cyc == m_due);
      exp_busy = m_pending && (m_lat > 1) && (cyc < m_due);
      exp_res  = exp_done ? m_val : m_result;
      check("cyc_done", {31'b0, done}, {31'b0, exp_done});
      check("cyc_busy", {31'b0, busy}, {31'b0, exp_busy});
      check("cyc_result", result, exp_res);
      if (exp_done) begin
        m_result  = m_val;
        m_pending = 0;
      end
      @(posedge clk);
      if (rst) begin
        m_pending = 0;
        m_result  = '0;
      end else if (start && !m_pending) begin
        m_pending = 1;
        m_lat     = ref_lat(op, A, B);
        m_due     = cyc + m_lat;
        m_val     = ref_result(op, A, B);
      end
      cyc++;
    end
  end

  // Drive a start for one cycle, then scramble the inputs.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 4'($urandom); A = $urandom; B = $urandom;
  endtask

  // Called right after issue; returns cycles from start to done.
  task automatic wait_done(input bit junk, output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 60) begin
      busy_cnt += int'(busy);
      if (junk && $urandom_range(3) == 0) begin
        start = 1'b1; op = 4'($urandom); A = $urandom; B = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("done_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic run_req(input string name, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit, input int lit_lat);
    int lat, bc;
    check({name, "_model"}, ref_result(o, a, b), lit);
    issue(o, a, b);
    wait_done(1'b0, lat, bc);
    check({name, "_lat"}, lat, lit_lat);
    check({name, "_busycnt"}, bc, (lit_lat == 33) ? 32 : 0);
    check({name, "_result"}, result, lit);
    $display("req %s op=%b A=%h B=%h -> %h lat=%0d", name, o, a, b, result, lat);
  endtask

  initial begin
    int lat, bc, dc;
    logic [3:0]  o;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, issued back to back (each start lands in a done cycle).
    run_req("mul",    4'b1000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    run_req("mulh",   4'b1001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
    run_req("mulhu",  4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    run_req("mulhsu", 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
    run_req("div",    4'b1100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_req("rem",    4'b1110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_req("divu",   4'b1101, 32'd100,      32'd7,        32'd14,       33);
    run_req("remu",   4'b1111, 32'd100,      32'd7,        32'd2,        33);
    run_req("divu0",  4'b1101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_req("rem0",   4'b1110, 32'd5,        32'd0,        32'd5,        1);
    run_req("divovf", 4'b1100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_req("removf", 4'b1110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run_req("notm",   4'b0011, 32'd5,        32'd9,        32'd0,        1);
    run_req("divu2",  4'b1101, 32'd1000,     32'd3,        32'd333,      33);

    // Reset in the 10th CALC cycle aborts without a done pulse.
    issue(4'b1100, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_result", result, 32'd0);
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      dc += int'(done);
    end
    check("abort_no_done", dc, 0);
    $display("req abort DIV 1000/3 reset in CALC, dones=%0d", dc);

    // Starts while busy are ignored: exactly one done.
    issue(4'b1101, 32'd1000, 32'd7);
    dc = 0;
    for (int n = 0; n < 60; n++) begin
      if (n < 5) begin
        start = 1'b1; op = 4'b1000; A = 32'd3; B = 32'd3;
      end else begin
        start = 1'b0;
      end
      dc += int'(done);
      @(negedge clk);
    end
    check("ignore_dones", dc, 1);
    check("ignore_result", result, 32'd142);
    $display("req ignore DIVU 1000/7 with busy starts, dones=%0d result=%h", dc, result);

    // Randomized traffic with busy-time junk starts and random idle gaps.
    for (int i = 0; i < 200; i++) begin
      o = 4'($urandom);
      if ($urandom_range(3) != 0) o[3] = 1'b1;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(9))
        0: b = '0;
        1: begin a = MIN_INT; b = '1; end
        2: begin a = 32'($urandom_range(40)) - 32'd20; b = 32'($urandom_range(40)) - 32'd20; end
        3: b = 32'($urandom_range(15));
        default: ;
      endcase
      issue(o, a, b);
      wait_done(1'b1, lat, bc);
      check("rand_result", result, ref_result(o, a, b));
      check("rand_lat", lat, ref_lat(o, a, b));
      $display("req rand op=%b A=%h B=%h -> %h lat=%0d", o, a, b, result, lat);
      if ($urandom_range(1) == 0) repeat ($urandom_range(3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Multi-cycle RISC-V M-extension unit.
- Computes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU using the same 4-bit operation codes 4'b1000–4'b1111 that the datapath ALU decodes.
- Sits beside the ALU in the execute stage:
  - The pipeline issues a request with a start pulse.
  - The pipeline stalls while busy is high.
  - The pipeline captures result when done pulses.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only when busy=0.
- op  in  4  operation code:
  - 1000 MUL, 1001 MULH, 1010 MULHSU, 1011 MULHU.
  - 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
- A  in  32  operand rs1; sampled at the accepting edge.
- B  in  32  operand rs2; sampled at the accepting edge.
- busy  out  1  operation in progress; new start ignored.
- done  out  1  one-cycle pulse; result valid in this cycle.
- result  out  32  last completed result; held until the next completion.

## Operation
- FSM states:
  - IDLE: busy=0.
  - CALC: busy=1; 5-bit iteration counter runs 31→0.
- IDLE + start, normal op: latch op; latch operand magnitudes and sign flags; clear the accumulator; enter CALC.
- Operand signedness:
  - Signed: MULH (A and B), MULHSU (A only), DIV/REM (A and B).
  - Unsigned: MUL (low word is sign-independent), MULHU, DIVU, REMU.
- Multiply: unsigned shift-add, one multiplier bit per cycle, 64-bit product.
  - Negate the product when the operand signs differ. For MULHSU this reduces to sign(A).
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide: restoring, one quotient bit per cycle on |A| and |B|.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
- On the edge where the counter is 0: apply the sign fix, load result, assert done, return to IDLE.
- Special cases are resolved in IDLE without entering CALC; result is loaded and done asserted on the next edge:
  - B==0, DIV/DIVU: result 32'hFFFFFFFF.
  - B==0, REM/REMU: result A.
  - DIV with A==32'h80000000, B==32'hFFFFFFFF: result 32'h80000000.
  - REM with A==32'h80000000, B==32'hFFFFFFFF: result 0.
  - op[3]==0 (not an M op): result 0.
- start while busy=1 is ignored; no queueing.
- The current request completes unchanged; A, B and op may change freely after acceptance.
- start in a done cycle is accepted, since busy=0 then, so back-to-back requests are supported.
- Flags Zero/Negative/Overflow/Carry are not produced; the ALU owns them.

## Timing
- Reset values: busy=0, done=0, result=0, FSM=IDLE, counter=0.
- rst high at any edge aborts an in-flight operation:
  - No done is produced.
  - result is cleared to 0.
  - rst has priority over start.
- Iterative op accepted at edge k:
  - busy=1 from cycle k+1 through k+32.
  - done=1 and result valid in cycle k+33, with busy=0.
- Special case accepted at edge k: done=1 in cycle k+1; busy never rises.
- done is high for exactly one cycle per accepted request.
- result changes only on the edge that raises done, or on reset.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MUL, MULH, MULHSU and MULHU use a single-cycle 33x33 signed combinational multiply (operands sign- or zero-extended per op).
  - They complete like a special case: done at k+1, busy never rises.
  - Divide remains iterative (33-cycle).
- MULDIV_FAST_MUL_EN undefined: all multiplies use the 32-iteration shift-add path (33-cycle latency).
- Results are bit-identical in both builds.

## Test plan
- MUL A=7, B=-3 (32'hFFFFFFFD) -> result 32'hFFFFFFEB.
  - Slow build: done exactly 33 cycles after start, busy high 32 cycles.
  - Fast build: done at 1 cycle.
- MULH 32'h80000000×32'h80000000 -> 32'h40000000.
- MULHU 32'hFFFFFFFF×32'hFFFFFFFF -> 32'hFFFFFFFE.
- MULHSU A=-1, B=32'hFFFFFFFF -> 32'hFFFFFFFF.
- DIV -7/2 -> 32'hFFFFFFFD.
- REM -7%2 -> 32'hFFFFFFFF.
- DIVU 100/7 -> 14.
- REMU 100%7 -> 2.
- Each of these completes in 33 cycles.
- DIVU 5/0 -> 32'hFFFFFFFF; REM 5/0 -> 5; DIV 32'h80000000/-1 -> 32'h80000000. Each: done 1 cycle after start, busy stays 0.
- Start DIV; pulse rst at cycle 10 of CALC -> busy=0 and result=0 next cycle, no done pulse.
- A start during busy is ignored (exactly one done).
- Start issued in the done cycle -> second result delivered 33 cycles later.
